// File: rtl/usb_speed_ctrl.sv
// Start/retry/timeout sequencer wrapped around usb_autodetect; publishes the final speed and status.
// Optional macro USB_SPEED_CTRL_STABLE_EN: require a steady speed for pSTABLE_CYCLES before accepting it.
module usb_speed_ctrl #(
  parameter int pCOUNTER_WIDTH  = 24,
  parameter int pRESTART_CYCLES = 10,
  parameter int pSTABLE_CYCLES  = 4
) (
  input  logic                      cwusb_clk,
  input  logic                      reset_i,
  input  logic [1:0]                I_mode,
  input  logic                      I_start,
  input  logic                      I_abort,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait1,
  input  logic [pCOUNTER_WIDTH-1:0] I_wait2,
  input  logic [pCOUNTER_WIDTH-1:0] I_timeout,
  input  logic [3:0]                I_max_retries,
  input  logic [1:0]                I_det_speed,
  output logic                      O_det_restart,
  output logic [pCOUNTER_WIDTH-1:0] O_det_wait1,
  output logic [pCOUNTER_WIDTH-1:0] O_det_wait2,
  output logic [1:0]                O_speed,
  output logic                      O_busy,
  output logic                      O_done,
  output logic                      O_fail,
  output logic [3:0]                O_retries
);

  localparam logic [1:0] USB_SPEED_AUTO = 2'd0;
  localparam int RCW = $clog2(pRESTART_CYCLES + 1);
  localparam logic [RCW-1:0] RESTART_LAST = RCW'(pRESTART_CYCLES - 1);
  localparam logic [RCW-1:0] RCNT_ONE = RCW'(1);
  localparam logic [pCOUNTER_WIDTH-1:0] CNT_ONE = pCOUNTER_WIDTH'(1);

  if (pRESTART_CYCLES < 1 || pSTABLE_CYCLES < 1) begin : g_bad_param
    $error("usb_speed_ctrl: pRESTART_CYCLES and pSTABLE_CYCLES must be >= 1");
  end

  typedef enum logic [2:0] {ST_IDLE, ST_RESTART, ST_WAIT, ST_DONE, ST_FAIL} state_t;

  state_t                    state_q, state_d;
  logic [RCW-1:0]            rcnt_q, rcnt_d;
  logic [pCOUNTER_WIDTH-1:0] wcnt_q, wcnt_d;
  logic [pCOUNTER_WIDTH-1:0] wait1_q, wait1_d, wait2_q, wait2_d, timeout_q, timeout_d;
  logic [3:0]                max_retries_q, max_retries_d, retries_q, retries_d;
  logic [1:0]                speed_q, speed_d;
  logic                      restart_q, restart_d;
  logic                      speed_ok;

`ifdef USB_SPEED_CTRL_STABLE_EN
  localparam int SCW = $clog2(pSTABLE_CYCLES + 1);
  localparam logic [SCW-1:0] STAB_N = SCW'(pSTABLE_CYCLES);
  logic [SCW-1:0] stab_q, stab_d;
  logic [1:0]     last_q;

  // Counts consecutive cycles of one unchanged non-AUTO speed; any change restarts at 1 (or 0 for AUTO).
  always_comb begin
    stab_d = '0;
    if (I_det_speed != USB_SPEED_AUTO)
      stab_d = (I_det_speed == last_q) ? stab_q + SCW'(1) : SCW'(1);
    speed_ok = (stab_d == STAB_N);
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i || state_q != ST_WAIT) begin
      stab_q <= '0;
      last_q <= USB_SPEED_AUTO;
    end else begin
      stab_q <= stab_d;
      last_q <= I_det_speed;
    end
  end
`else
  assign speed_ok = (I_det_speed != USB_SPEED_AUTO);
`endif

  always_comb begin
    state_d       = state_q;
    rcnt_d        = rcnt_q;
    wcnt_d        = wcnt_q;
    wait1_d       = wait1_q;
    wait2_d       = wait2_q;
    timeout_d     = timeout_q;
    max_retries_d = max_retries_q;
    retries_d     = retries_q;
    speed_d       = speed_q;
    restart_d     = 1'b0;
    if (I_abort) begin
      state_d = ST_IDLE;
      speed_d = USB_SPEED_AUTO;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (I_start) begin
            wait1_d       = I_wait1;
            wait2_d       = I_wait2;
            timeout_d     = I_timeout;
            max_retries_d = I_max_retries;
            retries_d     = 4'd0;
            // Forced-mode codes coincide with the USB_SPEED_* encodings.
            if (I_mode != 2'b00) begin
              state_d = ST_DONE;
              speed_d = I_mode;
            end else begin
              state_d   = ST_RESTART;
              speed_d   = USB_SPEED_AUTO;
              rcnt_d    = '0;
              restart_d = 1'b1;
            end
          end
        end
        ST_RESTART: begin
          if (rcnt_q == RESTART_LAST) begin
            state_d = ST_WAIT;
            wcnt_d  = '0;
          end else begin
            rcnt_d    = rcnt_q + RCNT_ONE;
            restart_d = 1'b1;
          end
        end
        ST_WAIT: begin
          if (speed_ok) begin
            state_d = ST_DONE;
            speed_d = I_det_speed;
          end else if (timeout_q != '0 && wcnt_q == timeout_q - CNT_ONE) begin
            if (retries_q < max_retries_q) begin
              retries_d = (retries_q == 4'hF) ? retries_q : retries_q + 4'd1;
              state_d   = ST_RESTART;
              rcnt_d    = '0;
              restart_d = 1'b1;
            end else begin
              state_d = ST_FAIL;
            end
          end else begin
            wcnt_d = wcnt_q + CNT_ONE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge cwusb_clk) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      rcnt_q        <= '0;
      wcnt_q        <= '0;
      wait1_q       <= '0;
      wait2_q       <= '0;
      timeout_q     <= '0;
      max_retries_q <= '0;
      retries_q     <= '0;
      speed_q       <= USB_SPEED_AUTO;
      restart_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      rcnt_q        <= rcnt_d;
      wcnt_q        <= wcnt_d;
      wait1_q       <= wait1_d;
      wait2_q       <= wait2_d;
      timeout_q     <= timeout_d;
      max_retries_q <= max_retries_d;
      retries_q     <= retries_d;
      speed_q       <= speed_d;
      restart_q     <= restart_d;
    end
  end

  assign O_det_restart = restart_q;
  assign O_det_wait1   = wait1_q;
  assign O_det_wait2   = wait2_q;
  assign O_speed       = speed_q;
  assign O_busy        = (state_q == ST_RESTART) || (state_q == ST_WAIT);
  assign O_done        = (state_q == ST_DONE);
  assign O_fail        = (state_q == ST_FAIL);
  assign O_retries     = retries_q;

endmodule

// File: tb/tb_usb_speed_ctrl.sv
// Scoreboarded random bench for usb_speed_ctrl: the driver pushes model outcomes, a negedge monitor checks them.
module tb_usb_speed_ctrl;

  localparam int W = 24;
  localparam int RST = 10;
  localparam int STAB = 4;
`ifdef USB_SPEED_CTRL_STABLE_EN
  localparam int LAT = STAB;
`else
  localparam int LAT = 1;
`endif
  localparam logic [1:0] AUTO = 2'd0, LS = 2'd1, FS = 2'd2, HS = 2'd3;

  logic cwusb_clk = 1'b0;
  logic reset_i = 1'b1;
  logic [1:0] I_mode = '0;
  logic I_start = 1'b0, I_abort = 1'b0;
  logic [W-1:0] I_wait1 = '0, I_wait2 = '0, I_timeout = '0;
  logic [3:0] I_max_retries = '0;
  logic [1:0] I_det_speed = '0;
  logic O_det_restart, O_busy, O_done, O_fail;
  logic [W-1:0] O_det_wait1, O_det_wait2;
  logic [1:0] O_speed;
  logic [3:0] O_retries;

  usb_speed_ctrl #(.pCOUNTER_WIDTH(W), .pRESTART_CYCLES(RST), .pSTABLE_CYCLES(STAB)) dut (
    .cwusb_clk(cwusb_clk), .reset_i(reset_i), .I_mode(I_mode), .I_start(I_start),
    .I_abort(I_abort), .I_wait1(I_wait1), .I_wait2(I_wait2), .I_timeout(I_timeout),
    .I_max_retries(I_max_retries), .I_det_speed(I_det_speed), .O_det_restart(O_det_restart),
    .O_det_wait1(O_det_wait1), .O_det_wait2(O_det_wait2), .O_speed(O_speed), .O_busy(O_busy),
    .O_done(O_done), .O_fail(O_fail), .O_retries(O_retries));

  always #5 cwusb_clk = ~cwusb_clk;

  typedef struct {
    logic         done;
    logic [1:0]   speed;
    logic [3:0]   retries;
    int           bursts;
    logic [W-1:0] w1, w2;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int compared = 0, mismatched = 0;
  int cyc = 0, t_ref = 0, cur_timeout = 0, txn = 0;
  bit mon_en = 1'b0;

  initial forever begin
    @(posedge cwusb_clk);
    cyc++;
  end

  task automatic chk(input string name, input longint act, input longint req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge cwusb_clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return O_det_restart;
      1:       return O_done;
      default: return O_fail;
    endcase
  endfunction

  task automatic wait_for(input string name, input int which, input logic val, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (sig(which) === val) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL %s: level %0d not seen within %0d cycles", name, val, bound);
    end
  endtask

  // Outcome of a run: attempt k (0-based) sees a speed d cycles into its wait window.
  function automatic exp_t model(input logic [1:0] mode, input int to, input int maxr, input int k,
                                 input int d, input logic [1:0] spd, input logic [W-1:0] w1, w2);
    exp_t e;
    e.w1 = w1;
    e.w2 = w2;
    if (mode != AUTO) begin
      e.done = 1'b1; e.speed = mode; e.retries = 4'd0; e.bursts = 0; e.lat = 1;
    end else if (to == 0 || (k <= maxr && d + LAT <= to)) begin
      e.done = 1'b1; e.speed = spd; e.retries = 4'(k); e.bursts = k + 1; e.lat = LAT;
    end else begin
      e.done = 1'b0; e.speed = AUTO; e.retries = 4'(maxr); e.bursts = maxr + 1; e.lat = -1;
    end
    return e;
  endfunction

  // Monitor: burst lengths, wait-window lengths and end-of-run results.
  initial begin
    bit p_rst = 1'b0, fresh = 1'b0, in_done = 1'b0, hold_bad = 1'b0;
    int rlen = 0, wlen = 0, bursts = 0;
    logic [1:0] held = '0;
    exp_t e;
    forever begin
      @(negedge cwusb_clk);
      if (!mon_en || reset_i) begin
        rlen = 0; wlen = 0; fresh = 1'b0; in_done = 1'b0; hold_bad = 1'b0;
      end else begin
        if ((O_done || O_fail) && fresh) begin
          fresh = 1'b0;
          if (O_fail) chk("fail_wait_len", wlen, cur_timeout);
          wlen = 0;
          if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL result: DUT finished with no pending expectation");
          end else begin
            e = sb.pop_front();
            txn++;
            $display("txn %0d: done=%0b fail=%0b speed=%0d retries=%0d bursts=%0d (exp done=%0b speed=%0d retries=%0d bursts=%0d)",
                     txn, O_done, O_fail, O_speed, O_retries, bursts, e.done, e.speed, e.retries, e.bursts);
            chk("done", O_done, e.done);
            chk("fail", O_fail, !e.done);
            chk("speed", O_speed, e.speed);
            chk("retries", O_retries, e.retries);
            chk("bursts", bursts, e.bursts);
            chk("wait1", O_det_wait1, e.w1);
            chk("wait2", O_det_wait2, e.w2);
            chk("busy_at_end", O_busy, 0);
            if (e.lat >= 0) chk("latency", cyc - t_ref, e.lat);
          end
          held = O_speed;
          hold_bad = 1'b0;
          in_done = O_done;
        end else if (in_done && O_done && O_speed !== held) begin
          hold_bad = 1'b1;
        end
        if (in_done && (!O_done || (I_start && !I_abort))) begin
          chk("speed_hold", hold_bad, 0);
          in_done = 1'b0;
        end
        if (I_start && !I_abort && !O_busy) begin
          fresh = 1'b1; bursts = 0; wlen = 0;
        end
        if (O_det_restart) begin
          if (!p_rst && wlen > 0) begin
            chk("wait_len", wlen, cur_timeout);
            wlen = 0;
          end
          rlen++;
        end else if (p_rst) begin
          chk("restart_len", rlen, RST);
          bursts++;
          rlen = 0;
        end
        if (O_busy && !O_det_restart) wlen++;
      end
      p_rst = O_det_restart;
    end
  end

  task automatic run(input logic [1:0] mode, input logic [W-1:0] w1, w2, input int to, input int maxr,
                     input int k, input int d, input logic [1:0] spd, input bit busy_start);
    bit ok;
    sb.push_back(model(mode, to, maxr, k, d, spd, w1, w2));
    tick();
    I_mode = mode; I_wait1 = w1; I_wait2 = w2; I_timeout = W'(to); I_max_retries = 4'(maxr);
    I_start = 1'b1;
    t_ref = cyc;
    cur_timeout = to;
    tick();
    I_start = 1'b0;
    I_mode = 2'($urandom); I_wait1 = W'($urandom); I_wait2 = W'($urandom);
    I_timeout = W'($urandom); I_max_retries = 4'($urandom);
    if (mode != AUTO) begin
      repeat (3) tick();
      return;
    end
    for (int a = 0; a <= maxr; a++) begin
      wait_for("restart_rise", 0, 1'b1, 300, ok);
      if (!ok) return;
      wait_for("restart_fall", 0, 1'b0, RST + 5, ok);
      if (!ok) return;
      if (a == 0 && busy_start) begin
        I_start = 1'b1;
        I_mode = 2'(1 + $urandom_range(2));
      end
      if (a == k) begin
        for (int j = 0; j < d; j++) begin
          tick();
          I_start = 1'b0;
        end
        I_det_speed = spd;
        t_ref = cyc;
        tick();
        I_start = 1'b0;
        wait_for("done_rise", 1, 1'b1, LAT + 10, ok);
        I_det_speed = 2'($urandom);
        repeat (3) tick();
        I_det_speed = AUTO;
        return;
      end
      tick();
      I_start = 1'b0;
    end
    wait_for("fail_rise", 2, 1'b1, 300, ok);
    repeat (2) tick();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_restart"}, O_det_restart, 0);
    chk({tag, "_wait1"}, O_det_wait1, 0);
    chk({tag, "_wait2"}, O_det_wait2, 0);
    chk({tag, "_speed"}, O_speed, AUTO);
    chk({tag, "_busy"}, O_busy, 0);
    chk({tag, "_done"}, O_done, 0);
    chk({tag, "_fail"}, O_fail, 0);
    chk({tag, "_retries"}, O_retries, 0);
  endtask

  initial begin
    bit ok;
    int to, maxr, k, d;
    logic [1:0] mode, spd;
    logic [W-1:0] w1, w2;
    repeat (3) tick();
    chk_reset_vals("reset");
    reset_i = 1'b0;
    mon_en = 1'b1;

    run(FS, 24'd5, 24'd6, 100, 0, 0, 0, FS, 1'b0);
    run(AUTO, 24'd32, 24'd32, 100, 0, 0, 20, HS, 1'b0);
    run(AUTO, 24'd7, 24'd9, 50, 2, 1, 10, LS, 1'b0);
    run(AUTO, 24'd1, 24'd2, 30, 1, 5, 0, LS, 1'b0);
    for (int n = 0; n < 40; n++) begin
      mode = ($urandom_range(3) == 0) ? 2'(1 + $urandom_range(2)) : AUTO;
      to   = ($urandom_range(7) == 0) ? 0 : 6 + $urandom_range(34);
      maxr = $urandom_range(3);
      k    = (to == 0) ? 0 : $urandom_range(maxr + 1);
      d    = (to == 0) ? $urandom_range(60) : $urandom_range(to - LAT);
      spd  = 2'(1 + $urandom_range(2));
      w1   = W'($urandom);
      w2   = W'($urandom);
      run(mode, w1, w2, to, maxr, k, d, spd, 1'($urandom_range(1)));
    end
    repeat (3) tick();
    chk("queue_empty", sb.size(), 0);
    mon_en = 1'b0;

    // Abort during the second restart burst: outputs drop next cycle, retries hold.
    I_mode = AUTO; I_timeout = 24'd3; I_max_retries = 4'd3; I_start = 1'b1;
    tick();
    I_start = 1'b0;
    wait_for("abort_rst1_fall", 0, 1'b0, RST + 5, ok);
    wait_for("abort_rst2_rise", 0, 1'b1, 20, ok);
    tick();
    I_abort = 1'b1;
    tick();
    I_abort = 1'b0;
    chk("abort_restart", O_det_restart, 0);
    chk("abort_busy", O_busy, 0);
    chk("abort_speed", O_speed, AUTO);
    chk("abort_retries", O_retries, 1);
    repeat (3) tick();
    chk("abort_idle_busy", O_busy, 0);
    chk("abort_idle_restart", O_det_restart, 0);

    // Reset in the second wait window.
    I_wait1 = 24'd77; I_wait2 = 24'd78; I_start = 1'b1;
    tick();
    I_start = 1'b0;
    wait_for("reset_rst1_fall", 0, 1'b0, RST + 5, ok);
    wait_for("reset_rst2_rise", 0, 1'b1, 20, ok);
    wait_for("reset_rst2_fall", 0, 1'b0, RST + 5, ok);
    tick();
    reset_i = 1'b1;
    tick();
    chk_reset_vals("midrun_reset");
    reset_i = 1'b0;

    // Abort and start together from DONE.
    I_mode = HS; I_start = 1'b1;
    tick();
    I_start = 1'b0;
    chk("forced_done", O_done, 1);
    chk("forced_speed", O_speed, HS);
    I_mode = AUTO; I_start = 1'b1; I_abort = 1'b1;
    tick();
    I_start = 1'b0; I_abort = 1'b0;
    chk("abort_start_done", O_done, 0);
    chk("abort_start_speed", O_speed, AUTO);
    repeat (2) tick();
    chk("abort_start_busy", O_busy, 0);
    chk("abort_start_restart", O_det_restart, 0);

`ifdef USB_SPEED_CTRL_STABLE_EN
    begin
      bit early = 1'b0;
      int t0;
      I_mode = AUTO; I_timeout = '0; I_start = 1'b1;
      tick();
      I_start = 1'b0;
      wait_for("stab_rst_fall", 0, 1'b0, RST + 5, ok);
      for (int r = 0; r < 4; r++) begin
        I_det_speed = FS;
        repeat (2) begin tick(); if (O_done) early = 1'b1; end
        I_det_speed = AUTO;
        repeat (2) begin tick(); if (O_done) early = 1'b1; end
      end
      chk("stable_no_early_done", early, 0);
      I_det_speed = FS;
      t0 = cyc;
      wait_for("stable_done", 1, 1'b1, 20, ok);
      chk("stable_latency", cyc - t0, STAB);
      chk("stable_speed", O_speed, FS);
      I_det_speed = AUTO;
      I_abort = 1'b1;
      tick();
      I_abort = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/usb_speed_ctrl.md
Name: usb_speed_ctrl

Overview:
Sequencer for the USB speed autodetector. On a start command it either applies a forced speed or drives the detector's restart and wait thresholds, then watches its speed result. If no result arrives within a programmable timeout, it retries a bounded number of times. It then publishes a final speed and status to the register block and the capture front end. It sits in the cwusb_clk domain between the register interface and usb_autodetect.

Parameters:
pCOUNTER_WIDTH, 24, width of wait thresholds and timeout counter
pRESTART_CYCLES, 10, cycles O_det_restart is held high per attempt (>=1)
pSTABLE_CYCLES, 4, stability window used only when the optional feature is enabled (>=1)

Ports:
cwusb_clk  input  1  sole clock
reset_i  input  1  synchronous active-high reset
I_mode  input  2  00 auto; 01 force LS; 10 force FS; 11 force HS; sampled on I_start
I_start  input  1  single-cycle start pulse; ignored while O_busy
I_abort  input  1  return to IDLE; has priority over all events except reset
I_wait1  input  pCOUNTER_WIDTH  line-high threshold; latched on accepted start
I_wait2  input  pCOUNTER_WIDTH  line-low threshold; latched on accepted start
I_timeout  input  pCOUNTER_WIDTH  per-attempt timeout in cycles; latched on start; 0 means no timeout
I_max_retries  input  4  extra attempts after the first; latched on start
I_det_speed  input  2  speed from autodetector (USB_SPEED_* encodings from defines.v)
O_det_restart  output  1  restart to autodetector
O_det_wait1  output  pCOUNTER_WIDTH  latched I_wait1
O_det_wait2  output  pCOUNTER_WIDTH  latched I_wait2
O_speed  output  2  final speed; USB_SPEED_AUTO until done
O_busy  output  1  high in RESTART or WAIT
O_done  output  1  high in DONE
O_fail  output  1  high in FAIL
O_retries  output  4  retries consumed in the current or last run

Behaviour:
- Reset (synchronous, reset_i high at a cwusb_clk edge):
  - All outputs 0, except O_speed = USB_SPEED_AUTO.
  - Latched thresholds cleared.
  - State IDLE.
- States: IDLE, RESTART, WAIT, DONE, FAIL.
- IDLE or DONE or FAIL + I_start:
  - Latch I_wait1, I_wait2, I_timeout and I_max_retries. Clear O_retries, O_done and O_fail. Set O_speed = AUTO.
  - I_mode != 00: next cycle DONE with O_speed = forced encoding (LS/FS/HS). No restart is issued.
  - I_mode == 00: next cycle RESTART.
- RESTART:
  - O_det_restart = 1 for exactly pRESTART_CYCLES cycles, registered output.
  - Then WAIT, with the timeout counter cleared and O_det_restart = 0.
- WAIT:
  - Counter increments each cycle.
  - I_det_speed != AUTO: next cycle DONE, O_speed = I_det_speed.
  - Else if I_timeout != 0 and counter == I_timeout-1:
    - If O_retries < latched max_retries: O_retries++, go to RESTART.
    - Otherwise go to FAIL; O_speed stays AUTO.
  - Speed and timeout on the same cycle: speed wins (DONE).
  - I_timeout == 0: wait indefinitely.
- DONE and FAIL are sticky until I_start, I_abort or reset.
  - I_start in these states restarts the sequence as from IDLE.
  - In DONE, O_speed holds even if I_det_speed changes.
- I_abort in any state:
  - Next state IDLE; O_det_restart = 0.
  - O_busy, O_done and O_fail = 0; O_speed = AUTO. O_retries holds.
  - I_abort and I_start on the same cycle: abort wins.
- I_start while busy is ignored; latched values are unchanged.
- O_det_wait1/2 are stable throughout a run. They change only on an accepted start or reset.
- O_retries saturates at 15.
- Latency from I_det_speed going valid in WAIT to O_done = 1 cycle (without the optional feature).

Optional Feature:
Macro USB_SPEED_CTRL_STABLE_EN.
- Defined: in WAIT, I_det_speed must be non-AUTO and unchanged for pSTABLE_CYCLES consecutive cycles before DONE.
  - Any change resets the stability count.
  - The timeout still runs during the stability window. On a timeout with the window incomplete, the retry/fail rules apply.
  - Latency from a valid speed to O_done = pSTABLE_CYCLES cycles.
- Undefined: the first non-AUTO value is accepted (1-cycle latency). No stability counter is instantiated.

Test Plan:
1. Forced mode: I_mode=10, I_start pulse -> O_done=1 one cycle later, O_speed=USB_SPEED_FS, O_det_restart never asserted.
2. Auto success: I_mode=00, I_wait1=32, I_wait2=32, I_timeout=100; drive I_det_speed=USB_SPEED_HS 20 cycles after restart ends.
   - O_det_restart high exactly 10 cycles; O_det_wait1=O_det_wait2=32.
   - O_done=1 and O_speed=HS one cycle later; O_retries=0.
3. Retry then success: I_timeout=50, I_max_retries=2, I_det_speed held AUTO through the first attempt, LS given during the second.
   - Two restart bursts; O_retries=1; O_done=1; O_speed=LS.
4. Exhaustion: I_timeout=30, I_max_retries=1, I_det_speed always AUTO.
   - Two restart bursts; O_fail=1; O_retries=1; O_speed=AUTO; O_busy=0.
5. Abort/reset mid-run:
   - I_abort during RESTART -> O_det_restart=0 next cycle, IDLE, O_busy=0.
   - Separately, reset_i during WAIT -> all outputs at reset values.
   - Same-cycle I_abort+I_start from DONE -> IDLE.
6. Optional feature (macro defined, pSTABLE_CYCLES=4): I_det_speed toggles FS/AUTO every 2 cycles, then holds FS.
   - No DONE while toggling.
   - O_done exactly 4 cycles after FS becomes steady.
